ser_word_tx: RTL and testbench

- Parallel-to-serial transmitter that sits directly upstream of the 3-bit serial-in shift register stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first onto the shift register's serial input d.
- After the downstream register has shifted WIDTH bits, its parallel output equals the accepted word. ser_word_tx flags that cycle with word_done.
- Optional bit-period stretching (DIV) and inter-word gap (GAP) support slower or enable-gated consumers.

---
 rtl/ser_pkg.sv | 24 ++
 rtl/ser_word_tx_bit_tick_gen.sv | 58 +++++
 rtl/ser_word_tx.sv | 164 ++++++++++++++++
 tb/tb_ser_word_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the parallel-to-serial word transmitter:
//   - state_e          : FSM state encoding (IDLE / SHIFT / GAP)
//   - IDLE_BIT_DEFAULT : default level on the serial line when not shifting
//   - min1_clog2()     : counter-width helper that never returns 0
// ----------------------------------------------------------------------------
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Bits needed to hold the values 0..n-1. A counter always gets at least
  // one bit, even when it only ever holds 0.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : ser_pkg

// File: rtl/ser_word_tx_bit_tick_gen.sv
// ----------------------------------------------------------------------------
// bit_tick_gen
// Bit-period divider. It counts clock cycles inside one serial bit period
// and raises a registered tick in the last cycle of each period.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   en   : the serial line is shifting in the NEXT cycle. The owner drives
//          this from its next-state logic, so tick can stay registered.
//   clr  : synchronous clear with priority over en
//   tick : high in the last cycle of each DIV-cycle bit period
// ----------------------------------------------------------------------------
module bit_tick_gen
  import ser_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = min1_clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          tick_q, tick_d;

  // The count restarts at 0 on the first cycle of a run and after every
  // tick. It only advances while below LAST, so it never wraps.
  always_comb begin
    cnt_d  = '0;
    run_d  = en && !clr;
    if (run_d && run_q && !tick_q) begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = run_d && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : bit_tick_gen

// File: rtl/ser_word_tx.sv
// ----------------------------------------------------------------------------
// ser_word_tx
// Parallel-to-serial transmitter. It accepts a WIDTH-bit word over a
// valid/ready handshake and sends it MSB-first on d_out, holding each bit
// for DIV cycles. After the last bit it can insert GAP idle cycles. The
// word_done pulse marks the cycle in which a downstream WIDTH-bit serial-in
// register holds the complete word.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   load_data  : word to transmit (sampled only at the accept edge)
//   load_valid : load_data is valid
//   load_ready : high in IDLE (decoded from the state register)
//   flush      : synchronous abort; overrides every other input
//   d_out      : registered serial bit
//   bit_strobe : registered; high in the last cycle of each bit period
//   busy       : high in SHIFT or GAP (decoded from the state register)
//   word_done  : registered one-cycle pulse after the last bit period
// ----------------------------------------------------------------------------
module ser_word_tx
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DIV      = 1,
  parameter int unsigned GAP      = 0,
  parameter logic        IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             flush,
  output logic             d_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned   BCW      = $clog2(WIDTH + 1);
  localparam int unsigned   GCW      = min1_clog2(GAP + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  // GAP_LAST only matters when GAP > 0; the guard keeps it in range otherwise.
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic             d_out_q, d_out_d;
  logic             done_q, done_d;
  logic             tick;

  // --------------------------------------------------------------------------
  // Bit-period timing. en is driven from the next state, so the strobe is
  // already valid in the first cycle of each bit.
  // --------------------------------------------------------------------------
  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_d == ST_SHIFT),
    .clr  (flush),
    .tick (tick)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first. A path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;

    if (flush) begin
      // Abort wins over an accept in the same cycle and never reports a word.
      state_d   = ST_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            shift_d   = load_data;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            shift_d = shift_q << 1;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              gap_cnt_d = '0;
              done_d    = 1'b1;
              state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GCW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // d_out is a registered copy of the MSB the shift register will hold next.
    d_out_d = (state_d == ST_SHIFT) ? shift_d[WIDTH-1] : IDLE_BIT;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      // NOTE: the shift register is reset on purpose. A word cut off by
      // reset must not leave stale bits that a later flush could expose.
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      d_out_q   <= IDLE_BIT;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      d_out_q   <= d_out_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign d_out      = d_out_q;
  assign bit_strobe = tick;
  assign word_done  = done_q;

endmodule : ser_word_tx

// File: tb/tb_ser_word_tx.sv
// ----------------------------------------------------------------------------
// tb_ser_word_tx
// Directed bench for ser_word_tx. It drives two instances:
//   a: WIDTH=3, DIV=1, GAP=0, feeding a 3-bit serial-in register model
//   b: WIDTH=3, DIV=3, GAP=2
// Cycle k is the clock period that follows accept edge E0 by k edges.
// Outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_ser_word_tx;

  logic       clk;
  logic       rst;

  logic [2:0] a_data;
  logic       a_valid, a_ready, a_flush, a_d_out, a_strobe, a_busy, a_done;
  logic [2:0] b_data;
  logic       b_valid, b_ready, b_flush, b_d_out, b_strobe, b_busy, b_done;

  logic [2:0] q_a;   // downstream serial-in shift register model

  int checks   = 0;
  int failures = 0;

  ser_word_tx #(.WIDTH(3), .DIV(1), .GAP(0), .IDLE_BIT(1'b0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .load_data  (a_data),
    .load_valid (a_valid),
    .load_ready (a_ready),
    .flush      (a_flush),
    .d_out      (a_d_out),
    .bit_strobe (a_strobe),
    .busy       (a_busy),
    .word_done  (a_done)
  );

  ser_word_tx #(.WIDTH(3), .DIV(3), .GAP(2), .IDLE_BIT(1'b0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .load_data  (b_data),
    .load_valid (b_valid),
    .load_ready (b_ready),
    .flush      (b_flush),
    .d_out      (b_d_out),
    .bit_strobe (b_strobe),
    .busy       (b_busy),
    .word_done  (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_a <= 3'b000;
    else      q_a <= {q_a[1:0], a_d_out};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    a_data  = 3'b101; a_valid = 1'b1; a_flush = 1'b0;
    b_data  = 3'b000; b_valid = 1'b0; b_flush = 1'b0;

    // ---- reset held 3 cycles with load_valid high: nothing is accepted ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_d_out", a_d_out, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_strobe", a_strobe, 0);
    check("rst_b_busy", b_busy, 0);
    a_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    check("rel_a_ready", a_ready, 1);
    check("rel_a_busy", a_busy, 0);
    check("rel_a_d_out", a_d_out, 0);
    check("rel_b_ready", b_ready, 1);

    // ---- single word 101 on a ----
    a_data = 3'b101; a_valid = 1'b1;
    tick();                              // E0 -> cycle 1
    a_valid = 1'b0; a_data = 3'b000;     // later data changes must not matter
    check("sw_c1_d", a_d_out, 1);
    check("sw_c1_busy", a_busy, 1);
    check("sw_c1_ready", a_ready, 0);
    check("sw_c1_strobe", a_strobe, 1);
    tick();
    check("sw_c2_d", a_d_out, 0);
    tick();
    check("sw_c3_d", a_d_out, 1);
    check("sw_c3_done", a_done, 0);
    tick();
    check("sw_c4_done", a_done, 1);
    check("sw_c4_d", a_d_out, 0);
    check("sw_c4_q", q_a, 3'b101);
    check("sw_c4_ready", a_ready, 1);
    check("sw_c4_busy", a_busy, 0);
    tick();
    check("sw_c5_done", a_done, 0);

    // ---- back-to-back 110 then 011 with load_valid held ----
    a_data = 3'b110; a_valid = 1'b1;
    tick();                              // E0 -> cycle 1
    a_data = 3'b011;                     // next word, accepted at E4
    check("bb_c1_d", a_d_out, 1);
    tick();
    check("bb_c2_d", a_d_out, 1);
    tick();
    check("bb_c3_d", a_d_out, 0);
    tick();
    check("bb_c4_d", a_d_out, 0);
    check("bb_c4_done", a_done, 1);
    check("bb_c4_q", q_a, 3'b110);
    check("bb_c4_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("bb_c5_d", a_d_out, 0);
    check("bb_c5_done", a_done, 0);
    tick();
    check("bb_c6_d", a_d_out, 1);
    tick();
    check("bb_c7_d", a_d_out, 1);
    check("bb_c7_done", a_done, 0);
    tick();
    check("bb_c8_done", a_done, 1);
    check("bb_c8_q", q_a, 3'b011);
    tick();

    // ---- stretch and gap on b: word 100, DIV=3, GAP=2 ----
    b_data = 3'b100; b_valid = 1'b1;
    tick();                              // E0 -> cycle 1
    b_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("sg_c%0d_d", c), b_d_out, (c <= 3) ? 1 : 0);
      check($sformatf("sg_c%0d_strobe", c), b_strobe, (c == 3 || c == 6 || c == 9) ? 1 : 0);
      check($sformatf("sg_c%0d_done", c), b_done, (c == 10) ? 1 : 0);
      check($sformatf("sg_c%0d_ready", c), b_ready, (c == 12) ? 1 : 0);
      check($sformatf("sg_c%0d_busy", c), b_busy, (c <= 11) ? 1 : 0);
      if (c < 12) tick();
    end

    // ---- flush during the 2nd bit of 111 on a ----
    a_data = 3'b111; a_valid = 1'b1;
    tick();                              // cycle 1
    a_valid = 1'b0;
    check("fl_c1_d", a_d_out, 1);
    tick();                              // cycle 2: second bit
    check("fl_c2_d", a_d_out, 1);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("fl_c3_d", a_d_out, 0);
    check("fl_c3_ready", a_ready, 1);
    check("fl_c3_busy", a_busy, 0);
    check("fl_c3_done", a_done, 0);
    tick();
    check("fl_c4_done", a_done, 0);

    // flush in IDLE blocks an accept in the same cycle
    a_data = 3'b010; a_valid = 1'b1; a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("fl_block_busy", a_busy, 0);
    check("fl_block_ready", a_ready, 1);
    tick();                              // accepted here -> cycle 1
    a_valid = 1'b0;
    check("fl_w2_c1_d", a_d_out, 0);
    check("fl_w2_c1_busy", a_busy, 1);
    tick();
    check("fl_w2_c2_d", a_d_out, 1);
    tick();
    check("fl_w2_c3_d", a_d_out, 0);
    tick();
    check("fl_w2_c4_done", a_done, 1);
    check("fl_w2_c4_q", q_a, 3'b010);
    tick();

    // ---- asynchronous reset mid-word ----
    a_data = 3'b111; a_valid = 1'b1;
    tick();                              // cycle 1
    a_valid = 1'b0;
    tick();                              // cycle 2
    check("ar_pre_busy", a_busy, 1);
    check("ar_pre_d", a_d_out, 1);
    #2 rst = 1'b0;                       // between edges
    #1;
    check("ar_d", a_d_out, 0);
    check("ar_busy", a_busy, 0);
    check("ar_strobe", a_strobe, 0);
    check("ar_ready", a_ready, 1);
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("ar_post%0d_done", k), a_done, 0);
      check($sformatf("ar_post%0d_busy", k), a_busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ser_word_tx
